// File: rtl/acq_event_fifo_arbiter.sv
// Round-robin arbiter that shares the Acquisition Event FIFO write port between
// several acquisition controllers, tags each word with its source index and counts accepted words.
module acq_event_fifo_arbiter #(
  parameter int N_SRC = 3,
  parameter int CNT_W = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [N_SRC-1:0]         src_en,
  input  logic [N_SRC-1:0]         src_valid,
  input  logic [32*N_SRC-1:0]      src_data,
  output logic [N_SRC-1:0]         src_ready,
  input  logic                     fifo_ready,
  output logic                     fifo_valid,
  output logic [31:0]              fifo_data,
  input  logic                     cnt_clr,
  output logic [CNT_W*N_SRC-1:0]   src_count,
  output logic                     busy
);

  typedef enum logic [1:0] {
    ARB  = 2'b01,
    XFER = 2'b10
  } state_t;

  state_t           state;
  logic [2:0]       rr_ptr;
  logic [2:0]       gnt_idx;
  logic [2:0]       nxt_ptr;
  logic             gnt_found;
  logic [N_SRC-1:0] req;
  logic [28:0]      gnt_word;
  logic [CNT_W-1:0] cnt_q [N_SRC];
  int               scan_idx;

  assign req  = src_valid & src_en;
  assign busy = (state == XFER);

  // First eligible source at or above rr_ptr, wrapping modulo N_SRC.
  always_comb begin
    gnt_found = 1'b0;
    gnt_idx   = 3'd0;
    scan_idx  = 0;
    for (int k = 0; k < N_SRC; k++) begin
      scan_idx = int'(rr_ptr) + k;
      if (scan_idx >= N_SRC) scan_idx = scan_idx - N_SRC;
      if (!gnt_found && req[scan_idx]) begin
        gnt_found = 1'b1;
        gnt_idx   = 3'(scan_idx);
      end
    end
  end

  always_comb begin
    gnt_word  = 29'd0;
    src_ready = '0;
    for (int i = 0; i < N_SRC; i++) begin
      if (gnt_idx == 3'(i)) gnt_word = src_data[32*i +: 29];
      src_ready[i] = (state == ARB) && gnt_found && (gnt_idx == 3'(i));
    end
  end

  assign nxt_ptr = (gnt_idx == 3'(N_SRC-1)) ? 3'd0 : gnt_idx + 3'd1;

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= ARB;
      rr_ptr     <= 3'd0;
      fifo_valid <= 1'b0;
      fifo_data  <= 32'd0;
      for (int i = 0; i < N_SRC; i++) cnt_q[i] <= '0;
    end else begin
      case (state)
        ARB: begin
          if (gnt_found) begin
            fifo_data  <= {gnt_idx, gnt_word};
            fifo_valid <= 1'b1;
            rr_ptr     <= nxt_ptr;
            state      <= XFER;
          end
        end
        XFER: begin
          if (fifo_ready) begin
            fifo_valid <= 1'b0;
            fifo_data  <= 32'd0;
            state      <= ARB;
          end
        end
        default: state <= ARB;
      endcase
      // Clear wins over a same-cycle increment; counts stick at all-ones.
      for (int i = 0; i < N_SRC; i++) begin
        if (cnt_clr)
          cnt_q[i] <= '0;
        else if ((state == ARB) && gnt_found && (gnt_idx == 3'(i)) && (cnt_q[i] != {CNT_W{1'b1}}))
          cnt_q[i] <= cnt_q[i] + 1'b1;
      end
    end
  end

  for (genvar gi = 0; gi < N_SRC; gi++) begin : g_cnt_out
    assign src_count[CNT_W*gi +: CNT_W] = cnt_q[gi];
  end

endmodule

// File: tb/tb_acq_event_fifo_arbiter.sv
// Self-checking bench for acq_event_fifo_arbiter: directed scenarios plus a
// randomized run against a transaction-level reference model.
module tb_acq_event_fifo_arbiter;

  localparam int N  = 3;
  localparam int CW = 4;

  logic            clk = 1'b0;
  logic            reset;
  logic [N-1:0]    src_en;
  logic [N-1:0]    src_valid;
  logic [32*N-1:0] src_data;
  logic [N-1:0]    src_ready;
  logic            fifo_ready;
  logic            fifo_valid;
  logic [31:0]     fifo_data;
  logic            cnt_clr;
  logic [CW*N-1:0] src_count;
  logic            busy;

  int checks = 0;
  int errors = 0;

  // Reference model state
  bit          m_hold;
  logic [31:0] m_word;
  int          m_rr;
  int          m_cnt [N];

  acq_event_fifo_arbiter #(.N_SRC(N), .CNT_W(CW)) dut (
    .clk       (clk),
    .reset     (reset),
    .src_en    (src_en),
    .src_valid (src_valid),
    .src_data  (src_data),
    .src_ready (src_ready),
    .fifo_ready(fifo_ready),
    .fifo_valid(fifo_valid),
    .fifo_data (fifo_data),
    .cnt_clr   (cnt_clr),
    .src_count (src_count),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  function automatic int cnt_of(int i);
    return int'(src_count[CW*i +: CW]);
  endfunction

  function automatic int onehot_idx(logic [N-1:0] v);
    for (int i = 0; i < N; i++) if (v == N'(1 << i)) return i;
    return -1;
  endfunction

  function automatic int model_grant();
    int i;
    for (int k = 0; k < N; k++) begin
      i = (m_rr + k) % N;
      if (src_valid[i] && src_en[i]) return i;
    end
    return -1;
  endfunction

  // Leaves the bench at a falling edge with reset released and the DUT idle.
  task automatic do_reset();
    @(negedge clk);
    src_valid = '0;
    cnt_clr   = 1'b0;
    reset     = 1'b1;
    @(negedge clk);
    reset     = 1'b0;
  endtask

  task automatic test_reset();
    src_en = '1; src_valid = '0; src_data = '0; fifo_ready = 1'b0; cnt_clr = 1'b0;
    do_reset();
    #1;
    checks++; if (fifo_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_fifo_valid got %b want 0", fifo_valid); end
    checks++; if (fifo_data !== 32'd0) begin errors++; $display("[TB] FAIL reset_fifo_data got %h want 0", fifo_data); end
    checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy got %b want 0", busy); end
    checks++; if (src_ready !== 3'b000) begin errors++; $display("[TB] FAIL reset_src_ready got %b want 000", src_ready); end
    checks++; if (src_count !== '0) begin errors++; $display("[TB] FAIL reset_src_count got %h want 0", src_count); end
    @(negedge clk);
  endtask

  task automatic test_single_source();
    do_reset();
    src_en = 3'b111; fifo_ready = 1'b1; src_data = '0;
    src_data[63:32] = 32'h0512_3456;
    src_valid = 3'b010;
    #1;
    checks++; if (src_ready !== 3'b010) begin errors++; $display("[TB] FAIL single_grant got %b want 010", src_ready); end
    checks++; if (fifo_valid !== 1'b0) begin errors++; $display("[TB] FAIL single_valid_early got %b want 0", fifo_valid); end
    @(negedge clk);
    src_valid = 3'b000;
    #1;
    checks++; if (src_ready !== 3'b000) begin errors++; $display("[TB] FAIL single_ready_xfer got %b want 000", src_ready); end
    checks++; if (fifo_valid !== 1'b1) begin errors++; $display("[TB] FAIL single_valid got %b want 1", fifo_valid); end
    checks++; if (fifo_data !== 32'h2512_3456) begin errors++; $display("[TB] FAIL single_data got %h want 25123456", fifo_data); end
    checks++; if (busy !== 1'b1) begin errors++; $display("[TB] FAIL single_busy got %b want 1", busy); end
    checks++; if (cnt_of(1) != 1 || cnt_of(0) != 0) begin errors++; $display("[TB] FAIL single_count got c0=%0d c1=%0d want 0,1", cnt_of(0), cnt_of(1)); end
    @(negedge clk);
    #1;
    checks++; if (fifo_valid !== 1'b0 || busy !== 1'b0) begin errors++; $display("[TB] FAIL single_release got valid=%b busy=%b want 0,0", fifo_valid, busy); end
    @(negedge clk);
  endtask

  task automatic test_round_robin();
    int  n;
    int  g;
    bit  prev;
    logic [31:0] w [N];
    do_reset();
    src_en = 3'b111; fifo_ready = 1'b1;
    for (int i = 0; i < N; i++) begin
      w[i] = $urandom & 32'h1FFF_FFFF;
      src_data[32*i +: 32] = w[i];
    end
    src_valid = 3'b111;
    n = 0; prev = 1'b0;
    for (int c = 0; c < 12; c++) begin
      #1;
      if (src_ready !== 3'b000) begin
        g = onehot_idx(src_ready);
        checks++; if (g != n % N) begin errors++; $display("[TB] FAIL rr_order grant %0d got %0d want %0d", n, g, n % N); end
        checks++; if (prev) begin errors++; $display("[TB] FAIL rr_back_to_back at cycle %0d got consecutive grants want gap", c); end
        n++;
      end
      if (prev && c > 0) begin
        checks++; if (fifo_data[31:29] != 3'((n-1) % N) || fifo_data[28:0] != w[(n-1) % N][28:0]) begin
          errors++; $display("[TB] FAIL rr_data got %h want tag %0d word %h", fifo_data, (n-1) % N, w[(n-1) % N][28:0]);
        end
      end
      prev = (src_ready !== 3'b000);
      @(negedge clk);
    end
    src_valid = '0;
    checks++; if (n != 6) begin errors++; $display("[TB] FAIL rr_grant_count got %0d want 6", n); end
    for (int i = 0; i < N; i++) begin
      checks++; if (cnt_of(i) != 2) begin errors++; $display("[TB] FAIL rr_count src %0d got %0d want 2", i, cnt_of(i)); end
    end
  endtask

  task automatic test_backpressure();
    logic [31:0] w;
    int writes;
    do_reset();
    src_en = 3'b111; fifo_ready = 1'b0;
    w = $urandom & 32'h1FFF_FFFF;
    src_data = {$urandom, $urandom, w};
    src_valid = 3'b001;
    #1;
    checks++; if (src_ready !== 3'b001) begin errors++; $display("[TB] FAIL bp_grant got %b want 001", src_ready); end
    @(negedge clk);
    src_valid = 3'b111;
    writes = 0;
    for (int c = 0; c < 10; c++) begin
      #1;
      checks++; if (fifo_valid !== 1'b1 || fifo_data !== {3'd0, w[28:0]}) begin
        errors++; $display("[TB] FAIL bp_hold cycle %0d got valid=%b data=%h want 1 %h", c, fifo_valid, fifo_data, {3'd0, w[28:0]});
      end
      checks++; if (src_ready !== 3'b000 || busy !== 1'b1) begin
        errors++; $display("[TB] FAIL bp_ready_busy cycle %0d got ready=%b busy=%b want 000 1", c, src_ready, busy);
      end
      if (fifo_valid && fifo_ready) writes++;
      @(negedge clk);
    end
    fifo_ready = 1'b1; src_valid = 3'b000;
    for (int c = 0; c < 4; c++) begin
      #1;
      if (fifo_valid && fifo_ready) writes++;
      @(negedge clk);
    end
    checks++; if (writes != 1) begin errors++; $display("[TB] FAIL bp_writes got %0d want 1", writes); end
  endtask

  task automatic test_mask();
    logic [2:0]  exp_r [5];
    logic [31:0] w0;
    exp_r = '{3'b001, 3'b000, 3'b100, 3'b000, 3'b001};
    do_reset();
    src_en = 3'b101; fifo_ready = 1'b1;
    w0 = $urandom & 32'h1FFF_FFFF;
    src_data = {$urandom & 32'h1FFF_FFFF, $urandom & 32'h1FFF_FFFF, w0};
    src_valid = 3'b111;
    for (int c = 0; c < 5; c++) begin
      #1;
      checks++; if (src_ready !== exp_r[c]) begin errors++; $display("[TB] FAIL mask_grant cycle %0d got %b want %b", c, src_ready, exp_r[c]); end
      @(negedge clk);
    end
    src_en = 3'b111; fifo_ready = 1'b0;
    #1;
    checks++; if (fifo_data !== {3'd0, w0[28:0]} || src_ready !== 3'b000) begin
      errors++; $display("[TB] FAIL mask_held got data=%h ready=%b want %h 000", fifo_data, src_ready, {3'd0, w0[28:0]});
    end
    @(negedge clk);
    fifo_ready = 1'b1;
    #1;
    checks++; if (fifo_valid !== 1'b1 || fifo_data !== {3'd0, w0[28:0]}) begin
      errors++; $display("[TB] FAIL mask_held2 got valid=%b data=%h want 1 %h", fifo_valid, fifo_data, {3'd0, w0[28:0]});
    end
    @(negedge clk);
    #1;
    checks++; if (src_ready !== 3'b010) begin errors++; $display("[TB] FAIL mask_src1_turn got %b want 010", src_ready); end
    @(negedge clk);
    src_valid = '0;
  endtask

  task automatic test_reset_clear();
    do_reset();
    src_en = 3'b111; fifo_ready = 1'b0;
    src_data = {$urandom & 32'h1FFF_FFFF, $urandom & 32'h1FFF_FFFF, $urandom & 32'h1FFF_FFFF};
    src_valid = 3'b001;
    #1;
    checks++; if (src_ready !== 3'b001) begin errors++; $display("[TB] FAIL rst_grant got %b want 001", src_ready); end
    @(negedge clk);
    src_valid = 3'b000;
    #1;
    checks++; if (fifo_valid !== 1'b1) begin errors++; $display("[TB] FAIL rst_pre_valid got %b want 1", fifo_valid); end
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0; src_valid = 3'b011; fifo_ready = 1'b1;
    #1;
    checks++; if (fifo_valid !== 1'b0 || fifo_data !== 32'd0 || busy !== 1'b0) begin
      errors++; $display("[TB] FAIL rst_mid_xfer got valid=%b data=%h busy=%b want 0 0 0", fifo_valid, fifo_data, busy);
    end
    checks++; if (src_count !== '0) begin errors++; $display("[TB] FAIL rst_counts got %h want 0", src_count); end
    checks++; if (src_ready !== 3'b001) begin errors++; $display("[TB] FAIL rst_arb_ptr got %b want 001", src_ready); end
    @(negedge clk);
    src_valid = 3'b000;
    #1;
    checks++; if (cnt_of(0) != 1) begin errors++; $display("[TB] FAIL rst_count_after got %0d want 1", cnt_of(0)); end
    @(negedge clk);
    src_valid = 3'b100; cnt_clr = 1'b1;
    #1;
    checks++; if (src_ready !== 3'b100) begin errors++; $display("[TB] FAIL clr_grant got %b want 100", src_ready); end
    @(negedge clk);
    cnt_clr = 1'b0; src_valid = 3'b000;
    #1;
    checks++; if (src_count !== '0) begin errors++; $display("[TB] FAIL clr_priority got %h want 0", src_count); end
    checks++; if (fifo_valid !== 1'b1 || fifo_data[31:29] !== 3'd2) begin
      errors++; $display("[TB] FAIL clr_handshake got valid=%b tag=%0d want 1 2", fifo_valid, fifo_data[31:29]);
    end
    @(negedge clk);
  endtask

  task automatic test_saturation();
    do_reset();
    src_en = 3'b001; fifo_ready = 1'b1; src_valid = 3'b001;
    for (int c = 0; c <= 40; c++) begin
      #1;
      if (c < 40) begin
        checks++; if (src_ready !== ((c % 2 == 0) ? 3'b001 : 3'b000)) begin
          errors++; $display("[TB] FAIL sat_grant cycle %0d got %b want %b", c, src_ready, (c % 2 == 0) ? 3'b001 : 3'b000);
        end
      end
      if (c == 20) begin
        checks++; if (cnt_of(0) != 10) begin errors++; $display("[TB] FAIL sat_mid got %0d want 10", cnt_of(0)); end
      end
      if (c == 40) begin
        checks++; if (cnt_of(0) != 15) begin errors++; $display("[TB] FAIL sat_final got %0d want 15", cnt_of(0)); end
      end
      if (c == 39) src_valid = 3'b000;
      @(negedge clk);
    end
  endtask

  // Randomized traffic; sources keep valid and data stable until accepted.
  task automatic test_random();
    bit [N-1:0]  pend;
    logic [31:0] wd [N];
    logic [2:0]  exp_rdy;
    int g;
    do_reset();
    m_hold = 1'b0; m_word = '0; m_rr = 0;
    for (int i = 0; i < N; i++) begin m_cnt[i] = 0; wd[i] = '0; end
    pend = '0; src_en = 3'b111;
    for (int cyc = 0; cyc < 600; cyc++) begin
      for (int i = 0; i < N; i++) begin
        if (!pend[i] && $urandom_range(1, 0) == 1) begin
          pend[i] = 1'b1;
          wd[i] = $urandom & 32'h1FFF_FFFF;
        end else if (pend[i] && $urandom_range(15, 0) == 0) begin
          pend[i] = 1'b0;
        end
        src_data[32*i +: 32] = wd[i];
      end
      src_valid  = pend;
      if ($urandom_range(7, 0) == 0) src_en = 3'($urandom);
      fifo_ready = ($urandom_range(3, 0) != 0);
      cnt_clr    = ($urandom_range(31, 0) == 0);
      reset      = ($urandom_range(99, 0) == 0);
      g = model_grant();
      exp_rdy = (!m_hold && g >= 0) ? 3'(1 << g) : 3'b000;
      #1;
      if (!reset) begin
        checks++; if (src_ready !== exp_rdy) begin errors++; $display("[TB] FAIL rnd_ready cycle %0d got %b want %b", cyc, src_ready, exp_rdy); end
      end
      checks++; if (fifo_valid !== m_hold || busy !== m_hold) begin
        errors++; $display("[TB] FAIL rnd_valid cycle %0d got valid=%b busy=%b want %b", cyc, fifo_valid, busy, m_hold);
      end
      checks++; if (fifo_data !== m_word) begin errors++; $display("[TB] FAIL rnd_data cycle %0d got %h want %h", cyc, fifo_data, m_word); end
      for (int i = 0; i < N; i++) begin
        checks++; if (cnt_of(i) != m_cnt[i]) begin errors++; $display("[TB] FAIL rnd_count cycle %0d src %0d got %0d want %0d", cyc, i, cnt_of(i), m_cnt[i]); end
      end
      if (reset) begin
        m_hold = 1'b0; m_word = '0; m_rr = 0;
        for (int i = 0; i < N; i++) m_cnt[i] = 0;
      end else begin
        if (!m_hold && g >= 0) begin
          m_hold = 1'b1;
          m_word = {3'(g), wd[g][28:0]};
          m_rr = (g + 1) % N;
          if (m_cnt[g] < (1 << CW) - 1) m_cnt[g]++;
          pend[g] = 1'b0;
        end else if (m_hold && fifo_ready) begin
          m_hold = 1'b0;
          m_word = '0;
        end
        if (cnt_clr) for (int i = 0; i < N; i++) m_cnt[i] = 0;
      end
      @(negedge clk);
    end
    reset = 1'b0; cnt_clr = 1'b0; src_valid = '0;
  endtask

  initial begin
    reset = 1'b1; src_en = '0; src_valid = '0; src_data = '0; fifo_ready = 1'b0; cnt_clr = 1'b0;
    test_reset();
    test_single_source();
    test_round_robin();
    test_backpressure();
    test_mask();
    test_reset_clear();
    test_saturation();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog got timeout want completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule

// File: doc/acq_event_fifo_arbiter.md
Name: acq_event_fifo_arbiter

Overview:
- Shares the single Acquisition Event FIFO write port between several acquisition controllers: synchronous fill, circular-buffer and asynchronous.
- Each controller presents a 32-bit event-info word under a valid/ready handshake. The block grants sources round-robin and tags each word with its source index.
- It drives a registered write towards the FIFO and keeps per-source accepted-word counters for status readout.
- Sits between the channel acquisition controllers and the Acquisition Event FIFO, in the 40 MHz TTC clock domain.

Parameters:
- N_SRC, 3, number of requesting controllers; legal range 1..7.
- CNT_W, 16, width of each per-source accepted-word counter.

Ports:
- clk  input  1  40 MHz TTC clock.
- reset  input  1  synchronous, active-high reset.
- src_en  input  N_SRC  per-source enable mask; a disabled source is never granted.
- src_valid  input  N_SRC  source i has a word pending; the source holds valid and data stable until it sees src_ready[i].
- src_data  input  32*N_SRC  word of source i at bits [32*i+31:32*i]; bits [31:29] of each word are zero by format.
- src_ready  output  N_SRC  one-hot grant; the word is accepted on the edge where src_ready[i] is high.
- fifo_ready  input  1  FIFO can accept a word.
- fifo_valid  output  1  fifo_data is valid.
- fifo_data  output  32  {src_index[2:0], src_word[28:0]}.
- cnt_clr  input  1  synchronous clear of all counters.
- src_count  output  CNT_W*N_SRC  saturating accepted-word count per source.
- busy  output  1  high while a word is held (XFER state).

Behaviour:
- Reset values:
  - state = ARB, rr_ptr = 0.
  - fifo_valid = 0, fifo_data = 0.
  - src_ready = 0.
  - all src_count = 0, busy = 0.
- Reset mid-XFER discards the held word: fifo_valid drops at the next edge and no counter increments.
- The state machine is one-hot with two states, ARB and XFER.
- ARB:
  - Eligible set is req = src_valid & src_en.
  - If req is nonzero, grant the first set bit scanning from rr_ptr upward, wrapping modulo N_SRC.
  - src_ready[g] is high combinationally in that same cycle, so only ARB drives src_ready.
  - On that edge: fifo_data <= {g[2:0], src_data_g[28:0]}, fifo_valid <= 1, rr_ptr <= (g+1) mod N_SRC, src_count[g] increments, next state XFER.
  - If req is zero, stay in ARB with src_ready = 0.
- XFER:
  - src_ready = 0 and busy = 1.
  - fifo_valid and fifo_data hold stable until an edge with fifo_ready = 1.
  - On that edge: fifo_valid <= 0, fifo_data <= 0, next state ARB.
  - There is no combinational path from fifo_ready to src_ready.
- Latency and throughput:
  - Grant edge T → fifo_valid high from T+1.
  - With fifo_ready held high, the word leaves at edge T+1 and fifo_valid is low at T+2.
  - A new grant is possible in the ARB cycle after T+1, giving a peak rate of one word per 2 cycles.
- Bits [31:29] of the source word are overwritten by the tag; source 0 is tagged 3'd0.
- Changing src_en during XFER does not affect the held word; the new mask applies at the next ARB cycle.
- A source that drops src_valid before being granted loses nothing and is not counted.
- Counters:
  - Saturate at 2^CNT_W-1.
  - cnt_clr has priority over an increment in the same cycle; the count becomes 0.
  - cnt_clr does not disturb the handshake.
- rr_ptr advances only on a grant, which prevents starvation: with all N_SRC sources permanently valid, each is granted exactly once per N_SRC grants.

Test Plan:
1. Single source: src_valid = 3'b010, src_data_1 = 0x0512_3456, fifo_ready = 1 → src_ready = 3'b010 for 1 cycle; fifo_valid for 1 cycle with fifo_data = 0x2512_3456; src_count[1] = 1.
2. Round-robin: all three sources valid continuously, 6 grants → grant order 0,1,2,0,1,2; every src_count = 2; no back-to-back grants.
3. Backpressure: fifo_ready = 0 for 10 cycles after a grant → fifo_valid and fifo_data stable for 10 cycles, src_ready = 0 throughout, busy = 1; release at cycle 11 → exactly one FIFO write.
4. Mask: src_en = 3'b101, all sources valid → source 1 is never granted; then set src_en = 3'b111 during XFER → the held word is unchanged and source 1 is granted in its next round-robin turn.
5. Reset and clear: assert reset while in XFER → fifo_valid = 0 at the next edge, state ARB, counters 0. Separately, assert cnt_clr on the same cycle as a grant → src_count = 0.
6. Saturation: CNT_W = 4, 20 grants to source 0 → src_count[0] stops at 15.
